// File: rtl/irq_ctrl.sv
// Interrupt controller: three sources (sw, timer, ext) with a per-source enable mask,
// a global enable, and a one-deep IDLE/REQ/SERVICE request handshake with the core.
module irq_ctrl #(
    parameter int unsigned CAUSE_SW    = 3,
    parameter int unsigned CAUSE_TIMER = 7,
    parameter int unsigned CAUSE_EXT   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_interupt,
    input  logic        ext_irq,
    input  logic        sw_irq,
    input  logic        mie_we,
    input  logic [2:0]  mie_wdata,
    input  logic        gie_we,
    input  logic        gie_wdata,
    input  logic        irq_ack,
    input  logic        mret,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [2:0]  mip,
    output logic [2:0]  mie,
    output logic        gie,
    output logic        in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state;
    logic       saved_gie;
    logic [2:0] sel;
    logic [2:0] eligible;
    logic [2:0] pick;
    logic [2:0] mie_nxt;
    logic       gie_nxt;
    logic       drop;
    logic       timer_clr;

    function automatic logic [2:0] prio_pick(input logic [2:0] e);
        if (e[2])      return 3'b100;
        else if (e[0]) return 3'b001;
        else if (e[1]) return 3'b010;
        else           return 3'b000;
    endfunction

    function automatic logic [30:0] cause_code(input logic [2:0] s);
        if (s[2])      return 31'(CAUSE_EXT);
        else if (s[0]) return 31'(CAUSE_SW);
        else           return 31'(CAUSE_TIMER);
    endfunction

    always_comb begin
        eligible  = mip & mie & {3{gie}};
        pick      = prio_pick(eligible);
        mie_nxt   = mie_we ? mie_wdata : mie;
        gie_nxt   = gie_we ? gie_wdata : gie;
        // Withdrawal looks at the enables as they will be after this edge's writes.
        drop      = !gie_nxt || ((sel & mie_nxt) == 3'b000);
        timer_clr = (state == REQ) && irq_ack && sel[1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_cause  <= '0;
            mip        <= '0;
            mie        <= '0;
            gie        <= 1'b0;
            saved_gie  <= 1'b0;
            in_service <= 1'b0;
            sel        <= '0;
        end else begin
            // Timer pending is sticky; a new pulse beats a same-cycle clear.
            mip[0] <= sw_irq;
            mip[2] <= ext_irq;
            mip[1] <= timer_interupt | (mip[1] & ~timer_clr);
            mie    <= mie_nxt;
            gie    <= gie_nxt;
            case (state)
                IDLE: begin
                    if (eligible != 3'b000) begin
                        state     <= REQ;
                        irq_req   <= 1'b1;
                        sel       <= pick;
                        irq_cause <= {1'b1, cause_code(pick)};
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state      <= SERVICE;
                        irq_req    <= 1'b0;
                        saved_gie  <= gie;
                        gie        <= 1'b0;
                        in_service <= 1'b1;
                    end else if (drop) begin
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret) begin
                        state      <= IDLE;
                        gie        <= saved_gie;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    irq_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a behavioural model predicts every post-edge output
// snapshot, a negedge monitor pops and compares; directed scenarios then random traffic.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        timer_interupt = 1'b0;
    logic        ext_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic        mie_we = 1'b0;
    logic [2:0]  mie_wdata = '0;
    logic        gie_we = 1'b0;
    logic        gie_wdata = 1'b0;
    logic        irq_ack = 1'b0;
    logic        mret = 1'b0;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [2:0]  mip;
    logic [2:0]  mie;
    logic        gie;
    logic        in_service;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .timer_interupt(timer_interupt), .ext_irq(ext_irq),
        .sw_irq(sw_irq), .mie_we(mie_we), .mie_wdata(mie_wdata), .gie_we(gie_we),
        .gie_wdata(gie_wdata), .irq_ack(irq_ack), .mret(mret), .irq_req(irq_req),
        .irq_cause(irq_cause), .mip(mip), .mie(mie), .gie(gie), .in_service(in_service)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] cause;
        logic [2:0]  mip;
        logic [2:0]  mie;
        logic        gie;
        logic        svc;
    } snap_t;

    snap_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0=idle, 1=requesting, 2=servicing; src 0=sw, 1=timer, 2=ext.
    int          m_mode = 0;
    int          m_src = 0;
    logic        m_req = 1'b0;
    logic [31:0] m_cause = '0;
    logic [2:0]  m_mip = '0;
    logic [2:0]  m_mie = '0;
    logic        m_gie = 1'b0;
    logic        m_sgie = 1'b0;

    function automatic logic [31:0] code_of(int src);
        case (src)
            0: return 32'h8000_0003;
            1: return 32'h8000_0007;
            default: return 32'h8000_000B;
        endcase
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        cmp(name, act, exp);
    endtask

    task automatic step();
        int          n_mode = m_mode;
        int          n_src = m_src;
        logic        n_req = m_req;
        logic [31:0] n_cause = m_cause;
        logic [2:0]  n_mip;
        logic [2:0]  n_mie;
        logic        n_gie;
        logic        n_sgie = m_sgie;
        int          order[3] = '{2, 0, 1};
        bit          found = 0;
        snap_t       s;
        if (!rst) begin
            n_mode = 0; n_src = 0; n_req = 0; n_cause = '0;
            n_mip = '0; n_mie = '0; n_gie = 0; n_sgie = 0;
        end else begin
            n_mie = mie_we ? mie_wdata : m_mie;
            n_gie = gie_we ? gie_wdata : m_gie;
            n_mip[0] = sw_irq;
            n_mip[2] = ext_irq;
            if (timer_interupt) n_mip[1] = 1'b1;
            else if (m_mode == 1 && irq_ack && m_src == 1) n_mip[1] = 1'b0;
            else n_mip[1] = m_mip[1];
            if (m_mode == 0) begin
                foreach (order[k]) begin
                    if (!found && m_gie && m_mip[order[k]] && m_mie[order[k]]) begin
                        found = 1;
                        n_src = order[k];
                    end
                end
                if (found) begin
                    n_mode = 1; n_req = 1; n_cause = code_of(n_src);
                end
            end else if (m_mode == 1) begin
                if (irq_ack) begin
                    n_mode = 2; n_req = 0; n_sgie = m_gie; n_gie = 0;
                end else if (!n_gie || !n_mie[m_src]) begin
                    n_mode = 0; n_req = 0;
                end
            end else if (mret) begin
                n_mode = 0; n_gie = m_sgie;
            end
        end
        @(posedge clk);
        m_mode = n_mode; m_src = n_src; m_req = n_req; m_cause = n_cause;
        m_mip = n_mip; m_mie = n_mie; m_gie = n_gie; m_sgie = n_sgie;
        #1;
        s.req = m_req; s.cause = m_cause; s.mip = m_mip; s.mie = m_mie;
        s.gie = m_gie; s.svc = (m_mode == 2);
        exp_q.push_back(s);
        timer_interupt = 0; mie_we = 0; gie_we = 0; irq_ack = 0; mret = 0; rst = 1;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            cmp("irq_req", 32'(irq_req), 32'(e.req));
            cmp("irq_cause", irq_cause, e.cause);
            cmp("mip", 32'(mip), 32'(e.mip));
            cmp("mie", 32'(mie), 32'(e.mie));
            cmp("gie", 32'(gie), 32'(e.gie));
            cmp("in_service", 32'(in_service), 32'(e.svc));
        end
    end

    initial begin
        rst = 0; step(); rst = 0; step();
        chk("reset_cause", irq_cause, 32'h0);

        // Timer path
        mie_we = 1; mie_wdata = 3'b010; gie_we = 1; gie_wdata = 1; step();
        steps(3);
        timer_interupt = 1; step();
        chk("timer_mip", 32'(mip), 32'h2);
        step();
        chk("timer_req", 32'(irq_req), 32'h1);
        chk("timer_cause", irq_cause, 32'h8000_0007);
        step();
        irq_ack = 1; step();
        chk("timer_ack_mip", 32'(mip), 32'h0);
        chk("timer_ack_svc", 32'(in_service), 32'h1);
        mret = 1; step();

        // Priority with all three sources together
        mie_we = 1; mie_wdata = 3'b111; step();
        ext_irq = 1; sw_irq = 1; timer_interupt = 1; step();
        step();
        chk("prio_cause", irq_cause, 32'h8000_000B);
        irq_ack = 1; step();
        ext_irq = 0; steps(2);
        mret = 1; step();
        step();
        chk("prio_next_cause", irq_cause, 32'h8000_0003);
        irq_ack = 1; step();
        sw_irq = 0; mret = 1; step();
        steps(2);
        irq_ack = 1; step();
        mret = 1; step();
        steps(2);

        // Withdrawal without ack, then ack beating the same-cycle disable
        mie_we = 1; mie_wdata = 3'b010; step();
        timer_interupt = 1; steps(3);
        mie_we = 1; mie_wdata = 3'b000; step();
        chk("withdraw_req", 32'(irq_req), 32'h0);
        mie_we = 1; mie_wdata = 3'b010; steps(2);
        mie_we = 1; mie_wdata = 3'b000; irq_ack = 1; step();
        chk("ack_wins_svc", 32'(in_service), 32'h1);

        // Nesting blocked in service, released by mret
        mie_we = 1; mie_wdata = 3'b100; ext_irq = 1; steps(3);
        chk("nest_req", 32'(irq_req), 32'h0);
        mret = 1; step();
        step();
        chk("nest_cause", irq_cause, 32'h8000_000B);
        ext_irq = 0; irq_ack = 1; step();

        // Reset mid-service, later mret ignored, pulse coincident with reset lost
        rst = 0; timer_interupt = 1; step();
        chk("rst_svc", 32'(in_service), 32'h0);
        mret = 1; steps(2);

        // Timer set/clear collision
        mie_we = 1; mie_wdata = 3'b010; gie_we = 1; gie_wdata = 1; step();
        timer_interupt = 1; steps(3);
        timer_interupt = 1; irq_ack = 1; step();
        chk("collide_mip", 32'(mip), 32'h2);
        mret = 1; step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(0, 15) == 0) sw_irq = ~sw_irq;
            timer_interupt = ($urandom_range(0, 7) == 0);
            mie_we = ($urandom_range(0, 11) == 0);
            mie_wdata = 3'($urandom_range(0, 7));
            gie_we = ($urandom_range(0, 11) == 0);
            gie_wdata = ($urandom_range(0, 3) != 0);
            irq_ack = ($urandom_range(0, 2) == 0);
            mret = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 79) != 0);
            step();
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
